// File: rtl/div_seq_pkg.sv
// Shared types for the sequential restoring divider: FSM state encoding and
// the helper that sizes the step counter.
package div_seq_pkg;

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_RUN  = 2'd1,
    ST_DONE = 2'd2
  } div_state_e;

  function automatic int cnt_width(input int len);
    return (len <= 2) ? 1 : $clog2(len);
  endfunction

endpackage

// File: rtl/div_seq_step.sv
// One combinational restoring-division step: shift in the next dividend bit,
// trial-subtract the divisor and keep the difference only when it is non-negative.
module div_seq_step #(
  parameter int LEN = 16
) (
  input  logic [LEN:0]   rem,
  input  logic           msb,
  input  logic [LEN-1:0] divisor,
  output logic [LEN:0]   rem_next,
  output logic           qbit
);

  logic [LEN+1:0] shifted;
  logic [LEN+1:0] trial;

  // One spare bit above the LEN+1 remainder turns the borrow into a sign test.
  assign shifted  = {rem, msb};
  assign trial    = shifted - {2'b00, divisor};
  assign qbit     = ~trial[LEN+1];
  assign rem_next = qbit ? trial[LEN:0] : shifted[LEN:0];

endmodule

// File: rtl/div_seq.sv
// Sequential restoring divider, one quotient bit per clock, START/DONE handshake.
// Define DIV_SEQ_SIGNED_EN for two's-complement operands (magnitude divide + sign fix-up).
//
// Handshake: start is sampled on the rising edge in IDLE or DONE and ignored in RUN;
// done rises LEN+1 edges after the accepting edge and stays high, with q/r stable,
// until the next accepted start (done falls on that same edge).
module div_seq
  import div_seq_pkg::*;
#(
  parameter int LEN = 16
) (
  input  logic           clk,
  input  logic           rst,
  input  logic           start,
  input  logic [LEN-1:0] a,
  input  logic [LEN-1:0] b,
  output logic [LEN-1:0] q,
  output logic [LEN-1:0] r,
  output logic           done,
  output div_state_e     state_dbg
);

  localparam int CW = cnt_width(LEN);

  div_state_e     state, next_state;
  logic [CW-1:0]  cnt;
  logic [LEN-1:0] dvd;
  logic [LEN-1:0] dvs;
  logic [LEN:0]   rem;
  logic           neg_q, neg_r;

  logic [LEN-1:0] a_mag, b_mag;
  logic           sa, sb;
  logic           load, step_en, finish;

  logic [LEN:0]   step_rem;
  logic           step_q;
  logic [LEN-1:0] q_raw, r_raw, q_fix, r_fix;

  always_comb begin
`ifdef DIV_SEQ_SIGNED_EN
    sa    = a[LEN-1];
    sb    = b[LEN-1];
    a_mag = sa ? -a : a;
    b_mag = sb ? -b : b;
`else
    sa    = 1'b0;
    sb    = 1'b0;
    a_mag = a;
    b_mag = b;
`endif
  end

  div_seq_step #(.LEN(LEN)) u_step (
    .rem      (rem),
    .msb      (dvd[LEN-1]),
    .divisor  (dvs),
    .rem_next (step_rem),
    .qbit     (step_q)
  );

  // A zero divisor yields an all-ones magnitude quotient; never negate it.
  assign q_raw = {dvd[LEN-2:0], step_q};
  assign r_raw = step_rem[LEN-1:0];
  assign q_fix = neg_q ? -q_raw : q_raw;
  assign r_fix = neg_r ? -r_raw : r_raw;

  always_comb begin
    next_state = state;
    load       = 1'b0;
    step_en    = 1'b0;
    finish     = 1'b0;
    case (state)
      ST_IDLE: begin
        if (start) begin
          next_state = ST_RUN;
          load       = 1'b1;
        end
      end
      ST_RUN: begin
        step_en = 1'b1;
        if (cnt == '0) begin
          next_state = ST_DONE;
          finish     = 1'b1;
        end
      end
      ST_DONE: begin
        if (start) begin
          next_state = ST_RUN;
          load       = 1'b1;
        end
      end
      default: next_state = ST_IDLE;
    endcase
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state <= ST_IDLE;
      cnt   <= '0;
      dvd   <= '0;
      dvs   <= '0;
      rem   <= '0;
      neg_q <= 1'b0;
      neg_r <= 1'b0;
      q     <= '0;
      r     <= '0;
      done  <= 1'b0;
    end else begin
      state <= next_state;
      done  <= (state == ST_DONE) && !start;
      if (load) begin
        dvd   <= a_mag;
        dvs   <= b_mag;
        rem   <= '0;
        cnt   <= CW'(LEN - 1);
        neg_q <= (sa ^ sb) && (b != '0);
        neg_r <= sa;
      end else if (step_en) begin
        rem <= step_rem;
        dvd <= q_raw;
        cnt <= cnt - CW'(1);
        if (finish) begin
          q <= q_fix;
          r <= r_fix;
        end
      end
    end
  end

  assign state_dbg = state;

endmodule
